// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator.
// - state_e : FSM state encoding (StIdle, StAccum)
// - clog2   : constant ceil(log2(n)), used to size the sum and the frame counter
package product_accumulator_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StAccum = 1'b1
  } state_e;

  // ceil(log2(n)); returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/product_accumulator_frame_counter.sv
// Loadable up-counter tracking how many products of the current frame were taken.
// Ports:
//   clk_i      rising-edge clock
//   reset_i    synchronous active-high reset
//   clear_i    synchronous clear to zero
//   load_i     load load_val_i (lower priority than clear)
//   load_val_i value to load
//   inc_i      increment enable (lowest priority)
//   last_o     high when count == Max-1
module frame_counter
  import product_accumulator_pkg::*;
#(
  parameter int unsigned Max   = 4,
  parameter int unsigned Width = clog2(Max + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             inc_i,
  output logic             last_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == Width'(Max - 1));

endmodule

// File: rtl/product_accumulator.sv
// Sums fixed-length frames of AccCount products and emits one registered sum per frame.
// Ports:
//   clk_i        rising-edge clock
//   reset_i      synchronous active-high reset
//   product_i    unsigned product from the multiplier
//   in_valid_i   qualifies product_i this cycle
//   clear_i      abort the current frame (beats in_valid_i)
//   sum_o        last completed frame sum, held until the next frame completes
//   sum_valid_o  one-cycle pulse when sum_o updates
//   busy_o       a frame is partially accumulated
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int unsigned WordLength = 4,
  parameter int unsigned AccCount   = 4,
  parameter int unsigned AccWidth   = 2 * WordLength + clog2(AccCount)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [2*WordLength-1:0] product_i,
  input  logic                    in_valid_i,
  input  logic                    clear_i,
  output logic [AccWidth-1:0]     sum_o,
  output logic                    sum_valid_o,
  output logic                    busy_o
);

  localparam int unsigned CntWidth = clog2(AccCount + 1);

  state_e              state_q, state_d;
  logic [AccWidth-1:0] acc_q, acc_d;
  logic [AccWidth-1:0] sum_q, sum_d;
  logic                sum_valid_q, sum_valid_d;
  logic                cnt_clear, cnt_load, cnt_inc, cnt_last;
  logic [AccWidth-1:0] prod_ext;

  assign prod_ext = AccWidth'(product_i);

  frame_counter #(
    .Max   (AccCount),
    .Width (CntWidth)
  ) u_frame_counter (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .clear_i    (cnt_clear),
    .load_i     (cnt_load),
    .load_val_i (CntWidth'(1)),
    .inc_i      (cnt_inc),
    .last_o     (cnt_last)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    sum_valid_d = 1'b0;
    cnt_clear   = 1'b0;
    cnt_load    = 1'b0;
    cnt_inc     = 1'b0;
    if (clear_i) begin
      // Abort drops this cycle's product and leaves the last sum untouched.
      state_d   = StIdle;
      acc_d     = '0;
      cnt_clear = 1'b1;
    end else if (in_valid_i) begin
      unique case (state_q)
        StIdle: begin
          if (AccCount == 1) begin
            // Single-product frames complete immediately; never enter StAccum.
            sum_d       = prod_ext;
            sum_valid_d = 1'b1;
          end else begin
            acc_d    = prod_ext;
            cnt_load = 1'b1;
            state_d  = StAccum;
          end
        end
        StAccum: begin
          if (cnt_last) begin
            sum_d       = acc_q + prod_ext;
            sum_valid_d = 1'b1;
            acc_d       = '0;
            cnt_clear   = 1'b1;
            state_d     = StIdle;
          end else begin
            acc_d   = acc_q + prod_ext;
            cnt_inc = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign sum_o       = sum_q;
  assign sum_valid_o = sum_valid_q;
  assign busy_o      = (state_q == StAccum);

endmodule
